// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port (req/ack, programmable wait states).
// Optional misalignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [5:0]  op,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        stall,
  output logic        err
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             we_p0;
  logic [5:0]       op_p0;
  logic [11:0]      addr_p0;
  logic [31:0]      wdata_p0;
  logic             acc_we;
  logic [5:0]       acc_op;
  logic [11:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic             accept, commit, mis;
  logic [DEPTH_LOG2-1:0] widx;
  logic [31:0]      mem [0:(1<<DEPTH_LOG2)-1];

  function automatic logic [31:0] load_fmt(logic [31:0] w, logic [5:0] o, logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (o)
      6'h20:   load_fmt = {{24{b[7]}}, b};
      6'h24:   load_fmt = {24'd0, b};
      6'h21:   load_fmt = {{16{h[15]}}, h};
      6'h25:   load_fmt = {16'd0, h};
      default: load_fmt = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(logic [31:0] old, logic [31:0] wd,
                                              logic [5:0] o, logic [1:0] a);
    store_merge = old;
    case (o)
      6'h28:   store_merge[{a, 3'b000} +: 8] = wd[7:0];
      6'h29:   if (a[1]) store_merge[31:16] = wd[15:0];
               else      store_merge[15:0]  = wd[15:0];
      default: store_merge = wd;
    endcase
  endfunction

  // Access size depends on direction: unknown load ops act as lw, unknown store ops as sw.
  function automatic logic misaligned(logic w, logic [5:0] o, logic [1:0] a);
    logic is_byte, is_half;
    is_byte = w ? (o == 6'h28) : (o == 6'h20 || o == 6'h24);
    is_half = w ? (o == 6'h29) : (o == 6'h21 || o == 6'h25);
    if (is_byte)      misaligned = 1'b0;
    else if (is_half) misaligned = a[0];
    else              misaligned = (a != 2'b00);
  endfunction

  // With zero wait states the access completes on the acceptance edge, so use live inputs in IDLE.
  assign acc_we    = (state == S_IDLE) ? we    : we_p0;
  assign acc_op    = (state == S_IDLE) ? op    : op_p0;
  assign acc_addr  = (state == S_IDLE) ? addr  : addr_p0;
  assign acc_wdata = (state == S_IDLE) ? wdata : wdata_p0;
  assign widx      = acc_addr[DEPTH_LOG2+1:2];
  assign accept    = (state == S_IDLE) && req && !rst;
  assign commit    = !rst && (state != S_RESP) && (state_nxt == S_RESP);

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = misaligned(acc_we, acc_op, acc_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)                          cnt <= CNT_INIT;
      else if (state == S_WAIT && cnt != 0) cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (cnt == 0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack  = (state == S_RESP);
    busy = (state == S_WAIT);
  end

  assign stall = req & ~ack;

  // Request capture at acceptance; data only, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= we;
      op_p0    <= op;
      addr_p0  <= addr;
      wdata_p0 <= wdata;
    end
  end

  // Memory commit and read-data registration on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (commit && acc_we && !mis)
      mem[widx] <= store_merge(mem[widx], acc_wdata, acc_op, acc_addr[1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst)
      rdata <= '0;
    else if (commit)
      rdata <= (acc_we || mis) ? 32'd0 : load_fmt(mem[widx], acc_op, acc_addr[1:0]);
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (commit) err_q <= mis;
    else             err_q <= 1'b0;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
